// File: rtl/serial_addsub_if.sv
// serial_addsub_if: start/done handshake, operands and result fields of the bit-serial adder/subtractor.
interface serial_addsub_if #(parameter int WIDTH = 8);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    modport master (output start, sub, a, b, input busy, done, result, carry_out, overflow);
    modport slave  (input start, sub, a, b, output busy, done, result, carry_out, overflow);
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one full-adder cell and a carry register, LSB first.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_addsub_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, co_q, co_d, ov_q, ov_d;
    logic             s, maj, last;
    assign s    = a_q[0] ^ b_q[0] ^ c_q;
    assign maj  = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    assign last = cnt_q == CW'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == IDLE)  ? (bus.start ? SHIFT : IDLE) :
                  (state_q == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    end
    always_comb begin
        bus.busy      = state_q == SHIFT;
        bus.done      = state_q == DONE;
        bus.result    = res_q;
        bus.carry_out = co_q;
        bus.overflow  = ov_q;
    end
    // Subtract is a + ~b + 1: invert B on load and seed the carry with sub.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        r_d   = r_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        res_d = res_q;
        co_d  = co_q;
        ov_d  = ov_q;
        if (state_q == IDLE && bus.start) begin
            a_d   = bus.a;
            b_d   = bus.b ^ {WIDTH{bus.sub}};
            c_d   = bus.sub;
            cnt_d = '0;
        end else if (state_q == SHIFT) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = maj;
            r_d   = {s, r_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                res_d = r_d;
                co_d  = maj;
                ov_d  = c_q ^ maj;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
            res_q <= '0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            r_q   <= r_d;
            c_q   <= c_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
            co_q  <= co_d;
            ov_q  <= ov_d;
        end
    end
endmodule
